uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Wishbone-mapped UART receiver: the receive-side companion to the existing UART transmitter, sharing the same 64-bit tri-state peripheral bus. It deserialises 8N1 frames from i_uart_rx, buffers the bytes in a small FIFO and exposes data and status registers over Wishbone. It also drives a level interrupt while data is pending.

Parameters:
MAPPED_ADDRESS, 64'h100000020, base byte address of the 4 x 64-bit register window (32 bytes).
CLKS_PER_BIT, 868, i_clk cycles per bit (100 MHz / 115200); must be at least 4.
FIFO_DEPTH, 8, receive FIFO entries; power of two, at least 2.

Ports:
i_clk  in  1  single system clock; all logic on posedge.
i_reset  in  1  asynchronous, active-low reset.
i_wb_adr  in  64  Wishbone byte address.
i_wb_dat  in  64  Wishbone write data.
o_wb_dat  inout  64  read data; driven only on address match, else high-Z.
i_wb_we  in  1  write enable.
i_wb_sel  in  8  byte lane select; read data is masked per lane.
i_wb_stb  in  1  strobe.
o_wb_ack  inout  1  acknowledge; driven only on address match, else high-Z.
o_wb_stall  inout  1  driven 0 on match with cyc&stb, else high-Z.
i_wb_cyc  in  1  cycle.
i_uart_rx  in  1  serial input, idle high, asynchronous.
o_irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset (i_reset=0, asynchronous): FSM goes to IDLE; FIFO is emptied; sticky flags clear; ack latch=0; read latch=0; o_irq=0; synchroniser flops=1.
- i_uart_rx passes through a 2-flop synchroniser; edge detection uses the synchronised value.
- Register map (offset from MAPPED_ADDRESS):
  - 0x00 DATA (read): bits [7:0] are the FIFO head, bit 8 is valid. Reading a non-empty FIFO pops it. Reading an empty FIFO returns 0 and does not pop.
  - 0x08 STATUS (read): bit0 not_empty, bit1 full, bit2 overrun, bit3 frame_err, bit4 parity_err. Bits [11:8] hold the FIFO count. Writing 1 to bits 2, 3 or 4 clears that flag.
  - 0x10 and 0x18: reads return 0; writes are ignored.
  - Writes to DATA are ignored.
- Wishbone: ack is registered, asserted the cycle after a matched cyc&stb, and held while cyc&stb remains. Stall is always 0. Read data is registered on the same edge as ack. A pop occurs once per accepted strobe cycle.
- FSM:
  - IDLE: on a 1->0 edge, go to START with the counter set to CLKS_PER_BIT/2-1.
  - START: at count 0, if the line is still 0, go to DATA (counter=CLKS_PER_BIT-1, bit index=0). Otherwise treat as a glitch and return to IDLE.
  - DATA: at each count 0, shift the sampled bit in LSB-first and reload the counter. After bit 7, go to PARITY when parity is enabled, otherwise STOP.
  - STOP: at count 0, if the line is 1, push the byte. If it is 0, set frame_err, discard the byte and go to WAIT_IDLE. After a push, go to IDLE.
  - WAIT_IDLE: stay until the line has been 1 for one full bit time, then go to IDLE.
- FIFO push when full: byte dropped, overrun set, contents unchanged.
- Push and pop in the same cycle: both occur and the count is unchanged. On an empty FIFO, the pop is ignored and the push proceeds.
- A flag set event and a W1C clear of the same flag in the same cycle: the set wins.
- Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- o_irq is combinational from not_empty.

Optional Feature:
UART_RX_PARITY_EN:
- When defined, the FSM inserts a PARITY state after DATA that samples one even-parity bit.
- On a mismatch, parity_err is set and the byte is discarded, but the stop bit is still checked.
- When undefined, there is no PARITY state, STATUS bit4 reads 0, and frames are 8N1.

Decomposition:
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - register offset constants (REG_DATA=0x00, REG_STATUS=0x08);
  - STATUS bit index constants.
- Sub-module uart_rx_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by width and depth.

Test Plan:
- Send byte 0xA5 in 8N1 at CLKS_PER_BIT=16 -> o_irq rises after the stop-bit sample; DATA read returns 0x1A5; next DATA read returns 0x000; o_irq=0.
- 0.3-bit low glitch on an idle line -> no push, no flags, FSM returns to IDLE.
- Stop bit forced to 0 on byte 0x3C -> frame_err=1, count=0; write STATUS=0x08 -> frame_err=0.
- Send 9 bytes 0x01..0x09 with FIFO_DEPTH=8 -> full=1, overrun=1; 8 reads return 0x01..0x08.
- Pop DATA in the same cycle the 2nd byte is pushed (count=1) -> count stays 1 and bytes arrive in order.
- Assert i_reset=0 mid-frame (during DATA bit 4) -> FIFO is empty, FSM is IDLE, and the next complete byte 0x5A is received correctly.
- Read with i_wb_sel=8'h01 -> only [7:0] is returned and bit 8 is masked to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam logic [4:0] REG_DATA   = 5'h00;
  localparam logic [4:0] REG_STATUS = 5'h08;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_PARITY_ERR = 4;
  localparam int ST_COUNT_LSB  = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO; head is visible combinationally, pop on an empty FIFO is ignored.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Wishbone-mapped UART receiver: 8N1 deserialiser, receive FIFO, status flags and level irq.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data and stop bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [63:0] MAPPED_ADDRESS = 64'h100000020,
  parameter int          CLKS_PER_BIT   = 868,
  parameter int          FIFO_DEPTH     = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [63:0] i_wb_adr,
  input  logic [63:0] i_wb_dat,
  inout  wire  [63:0] o_wb_dat,
  input  logic        i_wb_we,
  input  logic [7:0]  i_wb_sel,
  input  logic        i_wb_stb,
  inout  wire         o_wb_ack,
  inout  wire         o_wb_stall,
  input  logic        i_wb_cyc,
  input  logic        i_uart_rx,
  output logic        o_irq
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
  rx_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             push_reg;
  logic             frame_err_reg;
  logic             overrun_reg;
  logic             ack_reg;
  logic [63:0]      rd_data_reg;
`ifdef UART_RX_PARITY_EN
  logic             parity_err_reg;
  logic             parity_bad_reg;
`endif

  logic [7:0]       fifo_head;
  logic             fifo_full, fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [63:0]      offset;
  logic             addr_match, is_data, is_status, cyc_stb, accept, pop;
  logic [2:0]       w1c;
  logic [63:0]      rd_word, rd_masked;
  logic             unused_bits;

  assign offset     = i_wb_adr - MAPPED_ADDRESS;
  assign addr_match = (offset[63:5] == '0);
  assign is_data    = ((offset[4:0] & 5'h18) == REG_DATA);
  assign is_status  = ((offset[4:0] & 5'h18) == REG_STATUS);
  assign cyc_stb    = addr_match & i_wb_cyc & i_wb_stb;
  // A held strobe is only accepted once: the ack cycle never re-triggers a pop.
  assign accept     = cyc_stb & ~ack_reg;
  assign pop        = accept & ~i_wb_we & is_data;
  assign w1c        = (accept & i_wb_we & is_status & i_wb_sel[0])
                      ? i_wb_dat[ST_PARITY_ERR:ST_OVERRUN] : 3'b000;
  assign unused_bits = ^{i_wb_dat[63:5], i_wb_dat[1:0], w1c[2]};

  assign o_wb_dat   = addr_match ? rd_data_reg : 64'bz;
  assign o_wb_ack   = addr_match ? ack_reg : 1'bz;
  assign o_wb_stall = cyc_stb ? 1'b0 : 1'bz;
  assign o_irq      = ~fifo_empty;

  uart_rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (push_reg),
    .push_data (shift_reg),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rd_word = '0;
    if (is_data) begin
      if (!fifo_empty) rd_word[8:0] = {1'b1, fifo_head};
    end else if (is_status) begin
      rd_word[ST_NOT_EMPTY] = ~fifo_empty;
      rd_word[ST_FULL]      = fifo_full;
      rd_word[ST_OVERRUN]   = overrun_reg;
      rd_word[ST_FRAME_ERR] = frame_err_reg;
`ifdef UART_RX_PARITY_EN
      rd_word[ST_PARITY_ERR] = parity_err_reg;
`endif
      rd_word[ST_COUNT_LSB +: FCW] = fifo_count;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign rd_masked[gi*8 +: 8] = i_wb_sel[gi] ? rd_word[gi*8 +: 8] : 8'h00;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) {rx_meta_reg, rx_sync_reg, rx_prev_reg} <= 3'b111;
    else          {rx_meta_reg, rx_sync_reg, rx_prev_reg} <= {i_uart_rx, rx_meta_reg, rx_sync_reg};
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ack_reg     <= 1'b0;
      rd_data_reg <= '0;
      overrun_reg <= 1'b0;
    end else begin
      ack_reg <= cyc_stb;
      if (accept) rd_data_reg <= i_wb_we ? 64'd0 : rd_masked;
      if (w1c[0]) overrun_reg <= 1'b0;
      if (push_reg && fifo_full) overrun_reg <= 1'b1;
    end
  end

  // Flag clears come first so that a same-cycle set overrides them.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      push_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
      parity_bad_reg <= 1'b0;
`endif
    end else begin
      push_reg <= 1'b0;
      if (w1c[1]) frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (w1c[2]) parity_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            cnt_reg   <= HALF_BIT;
            state_reg <= START;
          end
        end
        START: begin
          if (cnt_reg == '0) begin
            if (!rx_sync_reg) begin
              cnt_reg     <= FULL_BIT;
              bit_idx_reg <= 3'd0;
              state_reg   <= DATA;
`ifdef UART_RX_PARITY_EN
              parity_bad_reg <= 1'b0;
`endif
            end else begin
              state_reg <= IDLE;
            end
          end else cnt_reg <= cnt_reg - CNT_W'(1);
        end
        DATA: begin
          if (cnt_reg == '0) begin
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
            cnt_reg     <= FULL_BIT;
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7)
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
          end else cnt_reg <= cnt_reg - CNT_W'(1);
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == '0) begin
            if (^{shift_reg, rx_sync_reg}) begin
              parity_err_reg <= 1'b1;
              parity_bad_reg <= 1'b1;
            end
            cnt_reg   <= FULL_BIT;
            state_reg <= STOP;
          end else cnt_reg <= cnt_reg - CNT_W'(1);
        end
`endif
        STOP: begin
          if (cnt_reg == '0) begin
            if (rx_sync_reg) begin
`ifdef UART_RX_PARITY_EN
              push_reg <= ~parity_bad_reg;
`else
              push_reg <= 1'b1;
`endif
              state_reg <= IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              cnt_reg       <= FULL_BIT;
              state_reg     <= WAIT_IDLE;
            end
          end else cnt_reg <= cnt_reg - CNT_W'(1);
        end
        WAIT_IDLE: begin
          if (!rx_sync_reg)        cnt_reg <= FULL_BIT;
          else if (cnt_reg == '0)  state_reg <= IDLE;
          else                     cnt_reg <= cnt_reg - CNT_W'(1);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of single-byte vectors plus corner sequences.
module tb_uart_rx;
  localparam int          BIT    = 16;
  localparam int          DEPTH  = 8;
  localparam logic [63:0] BASE   = 64'h100000020;
  localparam logic [63:0] A_DATA = BASE;
  localparam logic [63:0] A_STAT = BASE + 64'd8;
  localparam logic [63:0] A_R10  = BASE + 64'd16;
  localparam logic [63:0] A_R18  = BASE + 64'd24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] wb_adr = '0;
  logic [63:0] wb_wdat = '0;
  logic        wb_we = 1'b0;
  logic [7:0]  wb_sel = '0;
  logic        wb_stb = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        uart_line = 1'b1;
  wire  [63:0] wb_rdat;
  wire         wb_ack;
  wire         wb_stall;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  sel;
    logic [63:0] exp_rd;
  } vec_t;
  vec_t vecs [8];

  uart_rx #(.MAPPED_ADDRESS(BASE), .CLKS_PER_BIT(BIT), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_wb_adr   (wb_adr),
    .i_wb_dat   (wb_wdat),
    .o_wb_dat   (wb_rdat),
    .i_wb_we    (wb_we),
    .i_wb_sel   (wb_sel),
    .i_wb_stb   (wb_stb),
    .o_wb_ack   (wb_ack),
    .o_wb_stall (wb_stall),
    .i_wb_cyc   (wb_cyc),
    .i_uart_rx  (uart_line),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("pass %s: 0x%0h", name, act);
    end
  endtask

  // Called and returns on a falling clock edge.
  task automatic wb_xfer(input logic [63:0] adr, input logic we, input logic [63:0] wdat,
                         input logic [7:0] sel, input string name, output logic [63:0] rdat);
    int waited = 0;
    wb_adr = adr; wb_we = we; wb_wdat = wdat; wb_sel = sel;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    while (wb_ack !== 1'b1 && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_ack"}, 64'(wb_ack), 64'd1);
    check({name, "_stall"}, 64'(wb_stall), 64'd0);
    rdat = wb_rdat;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [63:0] adr, input logic [7:0] sel, input string name,
                    input logic [63:0] exp);
    logic [63:0] got;
    wb_xfer(adr, 1'b0, 64'd0, sel, name, got);
    check(name, got, exp);
  endtask

  task automatic wr(input logic [63:0] adr, input logic [63:0] data, input string name);
    logic [63:0] got;
    wb_xfer(adr, 1'b1, data, 8'hFF, name, got);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val);
    uart_line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_line = d[i];
      repeat (BIT) @(negedge clk);
    end
    uart_line = stop_val;
    repeat (BIT) @(negedge clk);
    uart_line = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hFF, 64'h1A5};
    vecs[1] = '{8'h00, 8'hFF, 64'h100};
    vecs[2] = '{8'hFF, 8'hFF, 64'h1FF};
    vecs[3] = '{8'h5A, 8'h01, 64'h05A};
    vecs[4] = '{8'h3C, 8'h02, 64'h100};
    vecs[5] = '{8'h81, 8'h00, 64'h000};
    vecs[6] = '{8'hC3, 8'hF0, 64'h000};
    vecs[7] = '{8'h7E, 8'h03, 64'h17E};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_irq", 64'(irq), 64'd0);
    rd(A_STAT, 8'hFF, "reset_status", 64'd0);
    rd(A_DATA, 8'hFF, "reset_data", 64'd0);

    for (int i = 0; i < 8; i++) begin
      check($sformatf("vec%0d_irq_before", i), 64'(irq), 64'd0);
      send_frame(vecs[i].data, 1'b1);
      check($sformatf("vec%0d_irq_after", i), 64'(irq), 64'd1);
      rd(A_DATA, vecs[i].sel, $sformatf("vec%0d_data", i), vecs[i].exp_rd);
      check($sformatf("vec%0d_irq_popped", i), 64'(irq), 64'd0);
      rd(A_DATA, 8'hFF, $sformatf("vec%0d_empty", i), 64'd0);
    end

    // Short low glitch must be rejected at the start-bit midpoint.
    uart_line = 1'b0;
    repeat (5) @(negedge clk);
    uart_line = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("glitch_irq", 64'(irq), 64'd0);
    rd(A_STAT, 8'hFF, "glitch_status", 64'd0);

    send_frame(8'h3C, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    rd(A_STAT, 8'hFF, "frame_status", 64'h008);
    wr(A_STAT, 64'h008, "frame_clear_wr");
    rd(A_STAT, 8'hFF, "frame_cleared", 64'd0);

    for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b1);
    rd(A_STAT, 8'hFF, "ovr_status", 64'h807);
    for (int b = 1; b <= 8; b++) rd(A_DATA, 8'hFF, $sformatf("ovr_rd%0d", b), 64'h100 | 64'(b));
    rd(A_STAT, 8'hFF, "ovr_after", 64'h004);
    wr(A_STAT, 64'h004, "ovr_clear_wr");
    rd(A_STAT, 8'hFF, "ovr_cleared", 64'd0);

    send_frame(8'h77, 1'b1);
    rd(A_R10, 8'hFF, "r10_read", 64'd0);
    rd(A_R18, 8'hFF, "r18_read", 64'd0);
    wr(A_DATA, 64'hFF, "data_wr_ignored");
    wr(A_R10, 64'hFFFF, "r10_wr_ignored");
    rd(A_STAT, 8'hFF, "reserved_status", 64'h101);

    // Pop lands on the same clock edge as the second byte's push.
    fork
      send_frame(8'h88, 1'b1);
      begin
        int w = 0;
        logic [63:0] got;
        while (dut.push_reg !== 1'b1 && w < 12 * BIT) begin
          @(negedge clk);
          w++;
        end
        check("same_cycle_push_seen", 64'(dut.push_reg), 64'd1);
        wb_xfer(A_DATA, 1'b0, 64'd0, 8'hFF, "same_cycle_pop", got);
        check("same_cycle_pop_data", got, 64'h177);
      end
    join
    rd(A_STAT, 8'hFF, "same_cycle_status", 64'h101);
    rd(A_DATA, 8'hFF, "same_cycle_second", 64'h188);
    rd(A_STAT, 8'hFF, "same_cycle_drained", 64'd0);

    send_frame(8'h11, 1'b1);
    check("pre_reset_irq", 64'(irq), 64'd1);
    uart_line = 1'b0;
    repeat (5 * BIT + 8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("in_reset_irq", 64'(irq), 64'd0);
    uart_line = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("post_reset_irq", 64'(irq), 64'd0);
    rd(A_STAT, 8'hFF, "post_reset_status", 64'd0);
    send_frame(8'h5A, 1'b1);
    rd(A_STAT, 8'hFF, "post_reset_count", 64'h101);
    rd(A_DATA, 8'hFF, "post_reset_data", 64'h15A);
    check("post_reset_irq_end", 64'(irq), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
